// File: rtl/lcd_frame_driver.sv
// rtl/lcd_frame_driver.sv - 16x2 HD44780 frame driver; optional LCD_REFRESH_ON_CHANGE_EN idle-until-change refresh
module lcd_frame_driver #(
  parameter int POWERUP_CYCLES = 200000,
  parameter int EN_CYCLES      = 10,
  parameter int CMD_CYCLES     = 500,
  parameter int CLEAR_CYCLES   = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] lcd_data,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_db,
  output logic         init_done,
  output logic         frame_done
);

  localparam logic [31:0] LP_PWR_LAST = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] LP_EN_LAST  = 32'(EN_CYCLES - 1);
  localparam logic [31:0] LP_CMD_LAST = 32'(CMD_CYCLES - 1);
  localparam logic [31:0] LP_CLR_LAST = 32'(CLEAR_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_POWERUP, ST_INIT, ST_SNAP, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2, ST_DONE
`ifdef LCD_REFRESH_ON_CHANGE_EN
    , ST_IDLE
`endif
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

  state_t       r_state;
  phase_t       r_phase;
  logic [31:0]  r_cnt;
  logic [4:0]   r_idx;
  logic [255:0] r_frame;
  logic         r_en;
  logic         r_rs;
  logic [7:0]   r_db;
  logic         r_init_done;
  logic         r_frame_done;

  logic [7:0]   w_chars [0:31];
  logic [4:0]   w_idx_next;
  logic [31:0]  w_wait_last;

  // Init command table: function set 8-bit/2-line, display on, entry mode, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  for (genvar k = 0; k < 32; k++) begin : g_chars
    assign w_chars[k] = r_frame[255-8*k -: 8];
  end

  assign w_idx_next  = r_idx + 5'd1;
  // Only the clear command needs the long settle; characters equal to 0x01 do not.
  assign w_wait_last = (!r_rs && r_db == 8'h01) ? LP_CLR_LAST : LP_CMD_LAST;

  // Top sequencer with embedded per-byte SETUP/PULSE/HOLD/WAIT timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_POWERUP;
      r_phase      <= PH_SETUP;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame      <= '0;
      r_en         <= 1'b0;
      r_rs         <= 1'b0;
      r_db         <= 8'h00;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_POWERUP: begin
          if (r_cnt == LP_PWR_LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_db    <= init_cmd(2'd0);
            r_rs    <= 1'b0;
            r_phase <= PH_SETUP;
            r_state <= ST_INIT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_SNAP: begin
          r_frame <= lcd_data;
          r_db    <= 8'h80;
          r_rs    <= 1'b0;
          r_cnt   <= '0;
          r_phase <= PH_SETUP;
          r_state <= ST_ADDR1;
        end
        ST_DONE: begin
`ifdef LCD_REFRESH_ON_CHANGE_EN
          r_state <= ST_IDLE;
`else
          r_state <= ST_SNAP;
`endif
        end
`ifdef LCD_REFRESH_ON_CHANGE_EN
        ST_IDLE: begin
          if (lcd_data != r_frame) r_state <= ST_SNAP;
        end
`endif
        default: begin
          case (r_phase)
            PH_SETUP: begin
              r_en    <= 1'b1;
              r_cnt   <= '0;
              r_phase <= PH_PULSE;
            end
            PH_PULSE: begin
              if (r_cnt == LP_EN_LAST) begin
                r_en    <= 1'b0;
                r_cnt   <= '0;
                r_phase <= PH_HOLD;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
            PH_HOLD: begin
              r_cnt   <= '0;
              r_phase <= PH_WAIT;
            end
            default: begin
              if (r_cnt != w_wait_last) begin
                r_cnt <= r_cnt + 32'd1;
              end else begin
                r_cnt   <= '0;
                r_phase <= PH_SETUP;
                case (r_state)
                  ST_INIT: begin
                    if (r_idx == 5'd3) begin
                      r_init_done <= 1'b1;
                      r_state     <= ST_SNAP;
                    end else begin
                      r_idx <= w_idx_next;
                      r_db  <= init_cmd(w_idx_next[1:0]);
                    end
                  end
                  ST_ADDR1: begin
                    r_idx   <= 5'd0;
                    r_db    <= w_chars[0];
                    r_rs    <= 1'b1;
                    r_state <= ST_LINE1;
                  end
                  ST_LINE1: begin
                    if (r_idx == 5'd15) begin
                      r_db    <= 8'hC0;
                      r_rs    <= 1'b0;
                      r_state <= ST_ADDR2;
                    end else begin
                      r_idx <= w_idx_next;
                      r_db  <= w_chars[w_idx_next];
                    end
                  end
                  ST_ADDR2: begin
                    r_idx   <= 5'd16;
                    r_db    <= w_chars[16];
                    r_rs    <= 1'b1;
                    r_state <= ST_LINE2;
                  end
                  default: begin
                    if (r_idx == 5'd31) begin
                      r_frame_done <= 1'b1;
                      r_state      <= ST_DONE;
                    end else begin
                      r_idx <= w_idx_next;
                      r_db  <= w_chars[w_idx_next];
                    end
                  end
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

  assign lcd_en     = r_en;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_db     = r_db;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_frame_driver.sv
// tb/tb_lcd_frame_driver.sv - scoreboard bench for lcd_frame_driver
module tb_lcd_frame_driver;

  localparam int P_PWR  = 20;
  localparam int P_EN   = 2;
  localparam int P_CMD  = 4;
  localparam int P_CLR  = 10;
  localparam int T_BYTE = P_EN + 2 + P_CMD;
  localparam int CLR_GAP = P_CLR + P_EN + 3;
`ifdef LCD_REFRESH_ON_CHANGE_EN
  localparam int NEXT_GAP = P_CMD + P_EN + 5;
`else
  localparam int NEXT_GAP = P_CMD + P_EN + 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] lcd_data;
  logic         lcd_en, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0]   lcd_db;

  lcd_frame_driver #(
    .POWERUP_CYCLES(P_PWR), .EN_CYCLES(P_EN), .CMD_CYCLES(P_CMD), .CLEAR_CYCLES(P_CLR)
  ) dut (
    .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_db(lcd_db), .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
  endtask

  // Reference model: the byte stream the LCD must see, with spacing between enable falls.
  task automatic push_byte(input logic rs, input logic [7:0] db, input int gap);
    exp_t e;
    e.rs = rs; e.db = db; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38, 0);
    push_byte(1'b0, 8'h0C, T_BYTE);
    push_byte(1'b0, 8'h06, T_BYTE);
    push_byte(1'b0, 8'h01, T_BYTE);
  endtask

  task automatic push_frame(input logic [255:0] f, input int first_gap);
    push_byte(1'b0, 8'h80, first_gap);
    for (int k = 0; k < 32; k++) begin
      if (k == 16) push_byte(1'b0, 8'hC0, T_BYTE);
      push_byte(1'b1, 8'(f >> (8 * (31 - k))), T_BYTE);
    end
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] r = '0;
    for (int k = 0; k < 32; k++) r = {r[247:0], 8'($urandom_range(32, 126))};
    return r;
  endfunction

  // Monitor state
  int         ncyc = 0, last_fall = 0, last_clear = 0, n_pop = 0, fd_count = 0;
  logic       prev_en = 1'b0, prev_init = 1'b0, prev_fd = 1'b0, rise_rs = 1'b0;
  logic [7:0] rise_db = 8'h00;
  bit         flush = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (flush) begin
      flush     = 1'b0;
      prev_en   = 1'b0;
      prev_init = 1'b0;
      prev_fd   = 1'b0;
    end else if (!rst) begin
      if (lcd_en && !prev_en) begin
        rise_db = lcd_db;
        rise_rs = lcd_rs;
      end
      if (!lcd_en && prev_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {lcd_rs, lcd_db}, 9'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {lcd_rw, lcd_rs, lcd_db}, {1'b0, e.rs, e.db});
          chk("bus_stable_in_pulse", {rise_rs, rise_db}, {lcd_rs, lcd_db});
          if (e.gap != 0) chk("byte_gap", 64'(ncyc - last_fall), 64'(e.gap));
        end
        if (!lcd_rs && lcd_db == 8'h01) last_clear = ncyc;
        last_fall = ncyc;
        n_pop++;
      end
      if (init_done && !prev_init) chk("init_done_timing", 64'(ncyc - last_clear), 64'(P_CLR + 1));
      if (frame_done) begin
        if (prev_fd) chk("frame_done_width", 64'd2, 64'd1);
        else chk("frame_done_timing", 64'(ncyc - last_fall), 64'(P_CMD + 1));
        fd_count++;
      end
      prev_en   = lcd_en;
      prev_init = init_done;
      prev_fd   = frame_done;
    end
  end

  task automatic wait_pop(input int n);
    int b = 0;
    while (n_pop < n && b < 5000) begin @(negedge clk); b++; end
    chk("wait_bytes", 64'(n_pop >= n), 64'd1);
  endtask

  task automatic wait_fd(input int n);
    int b = 0;
    while (fd_count < n && b < 5000) begin @(negedge clk); b++; end
    chk("wait_frame_done", 64'(fd_count >= n), 64'd1);
  endtask

  // Called right after rst is released at posedge+1 (that posedge was the last reset edge).
  task automatic powerup_check();
    for (int j = -1; j <= 20; j++) begin
      @(negedge clk);
      if (j == -1) chk("post_reset_en_init", {lcd_en, init_done}, 2'b00);
      if (j == 18) chk("pwr_before_setup", {lcd_en, lcd_rs, lcd_db}, 10'h000);
      if (j == 19) chk("pwr_setup_0x38", {lcd_en, lcd_rs, lcd_db}, {2'b00, 8'h38});
      if (j == 20) chk("pwr_first_rise", {lcd_en, lcd_rs, lcd_db}, {2'b10, 8'h38});
    end
  endtask

  initial begin
    int   fd0;
    int   b;
    int   act;
    rst      = 1'b1;
    lcd_data = "HELLO WORLD     RV32I STARS 2024";
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_en", lcd_en, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_db", lcd_db, 8'h00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);

    push_init();
    push_frame(lcd_data, CLR_GAP);
    @(posedge clk); #1 rst = 1'b0;
    powerup_check();

    // Change the source during line-1 char 5; current frame must stay intact.
    wait_pop(10);
    @(posedge clk); #1 lcd_data = {32{8'h41}};
    push_frame(lcd_data, NEXT_GAP);

    for (int i = 1; i <= 3; i++) begin
      wait_fd(i);
      repeat (3) @(posedge clk);
      #1 lcd_data = rand_frame();
      push_frame(lcd_data, NEXT_GAP);
    end

    // Reset during an enable pulse.
    b = 0;
    while (!(lcd_en && !prev_en) && b < 2000) begin @(negedge clk); b++; end
    @(posedge clk); #1;
    chk("rst_mid_pulse_en_high", lcd_en, 1'b1);
    rst   = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    push_init();
    push_frame(lcd_data, CLR_GAP);
    fd0 = fd_count;
    @(posedge clk); #1 rst = 1'b0;
    powerup_check();
    wait_fd(fd0 + 1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

`ifdef LCD_REFRESH_ON_CHANGE_EN
    act = 0;
    repeat (1000) begin @(negedge clk); if (lcd_en) act++; end
    chk("idle_no_en", 64'(act), 64'd0);
    @(posedge clk); #1 lcd_data[0] = ~lcd_data[0];
    push_frame(lcd_data, 0);
    wait_fd(fd0 + 2);
    chk("refresh_queue_drained", 64'(exp_q.size()), 64'd0);
`else
    act = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/lcd_frame_driver.md
# lcd_frame_driver

Consumer of the 256-bit LCD buffer that the RAM exposes from data words 42–49. It snapshots the 32-character frame and drives a 16x2 HD44780-compatible character LCD over an 8-bit parallel write-only bus. It performs the power-up and initialization sequence, then repeatedly writes line 1 (characters 0–15) and line 2 (characters 16–31).

## Interface
Parameters:
- POWERUP_CYCLES, 200000: idle cycles after reset before the first command.
- EN_CYCLES, 10: width of each lcd_en high pulse, in cycles (≥1).
- CMD_CYCLES, 500: wait after each byte except clear (≥1).
- CLEAR_CYCLES, 20000: wait after the clear command 0x01 (≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- lcd_data  input  256  frame; char k = lcd_data[255-8k -: 8], so char 0 = bits 255:248.
- lcd_en  output  1  LCD enable strobe.
- lcd_rs  output  1  0 = command, 1 = character data.
- lcd_rw  output  1  tied 0 (write only).
- lcd_db  output  8  LCD data bus.
- init_done  output  1  high once the init sequence has completed.
- frame_done  output  1  one-cycle pulse after the last line-2 character's wait ends.

## Operation
- Top FSM states:
  - POWERUP: count POWERUP_CYCLES, then go to INIT.
  - INIT: send 0x38, 0x0C, 0x06, 0x01 in order, all with rs=0. After 0x01, set init_done and go to SNAP.
  - SNAP: capture lcd_data into a 256-bit frame register (1 cycle), then go to ADDR1.
  - ADDR1: send 0x80 with rs=0.
  - LINE1: send chars 0..15 with rs=1.
  - ADDR2: send 0xC0 with rs=0.
  - LINE2: send chars 16..31 with rs=1.
  - DONE: pulse frame_done, then go to SNAP (or IDLE, see Configuration).
- Byte sub-FSM (every byte):
  - SETUP: 1 cycle; lcd_rs and lcd_db driven, lcd_en=0.
  - PULSE: EN_CYCLES cycles with lcd_en=1.
  - HOLD: 1 cycle with lcd_en=0.
  - WAIT: CMD_CYCLES, or CLEAR_CYCLES if the byte is 0x01.
- lcd_rs and lcd_db stay stable from SETUP through the end of WAIT. They change only in the next byte's SETUP.
- Characters always come from the frame register. Changes to lcd_data mid-frame never appear until the next SNAP, so no tearing.
- Char index counter is 5 bits: LINE1 uses 0..15, LINE2 uses 16..31. Index 31 completes the frame; there is no wrap within a frame.
- lcd_rw is constant 0.

## Timing
- Reset values:
  - lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00.
  - init_done=0, frame_done=0.
  - Frame register = 0; all counters = 0; state POWERUP.
- Reset asserted in any state, including mid-pulse, forces all reset values on the next edge. lcd_en drops in that same cycle, and the full power-up and init sequence restarts.
- Byte period: T = EN_CYCLES + 2 + wait cycles.
- First SETUP of 0x38 occurs exactly POWERUP_CYCLES cycles after the first clk edge with rst low.
- init_done rises the cycle after 0x01's WAIT ends, coinciding with SNAP.
- frame_done is high for exactly one cycle.
- Frame cost: 34 bytes at T = EN_CYCLES + 2 + CMD_CYCLES, plus 1 SNAP cycle and 1 DONE cycle.
- No handshake on lcd_data; it is sampled only in SNAP.

## Configuration
- LCD_REFRESH_ON_CHANGE_EN defined:
  - DONE goes to IDLE.
  - IDLE compares lcd_data with the frame register every cycle. On any mismatch it goes to SNAP on the next cycle; otherwise it stays in IDLE with outputs stable and lcd_en=0.
- Not defined:
  - DONE goes straight to SNAP, giving continuous refresh. No IDLE state is built.

## Test plan
Bench overrides parameters to POWERUP_CYCLES=20, EN_CYCLES=2, CMD_CYCLES=4, CLEAR_CYCLES=10.
- Reset then release → outputs at reset values. First lcd_en rise occurs with lcd_db=0x38, rs=0; SETUP is at cycle 20.
- Init capture → bytes on each lcd_en fall are 0x38, 0x0C, 0x06, 0x01. Gap after 0x01 is 10 wait cycles. init_done rises the cycle after that wait ends.
- lcd_data = ASCII "HELLO WORLD     RV32I STARS 2024" → decoded stream is 0x80, then 16 line-1 chars with rs=1, 0xC0, then 16 line-2 chars. frame_done pulses once.
- Change lcd_data to all 0x41 during LINE1 char 5 → current frame still shows the original text. Next frame shows 32×0x41.
- Assert rst for 1 cycle while lcd_en=1 → lcd_en=0 and init_done=0 next cycle. Power-up restarts with the first 0x38 SETUP 20 cycles later.
- LCD_REFRESH_ON_CHANGE_EN defined, lcd_data held constant → exactly one frame after init, then no lcd_en activity for 1000 cycles. Flip bit 0 → new frame starts; its last char on line 2 reflects the flipped bit.
